// File: rtl/led_flow_ctrl_if.sv
// rtl/led_flow_ctrl_if.sv - control and LED output bundle for the running-light controller
interface led_flow_ctrl_if #(
    parameter int WIDTH = 16
);
    logic             en;
    logic [1:0]       mode;
    logic [1:0]       speed;
    logic [WIDTH-1:0] led;
    logic             step;
    logic             dir;

    modport master (
        output en, mode, speed,
        input  led, step, dir
    );

    modport slave (
        input  en, mode, speed,
        output led, step, dir
    );
endinterface

// File: rtl/led_flow_ctrl.sv
// rtl/led_flow_ctrl.sv - prescaled running-light controller with four selectable patterns
module led_flow_ctrl #(
    parameter int WIDTH    = 16,
    parameter int BASE_DIV = 10_000_000,
    parameter int DIV_W    = 32
) (
    input  logic               clk,
    input  logic               rstn,
    led_flow_ctrl_if.slave     bus
);

    typedef enum logic [1:0] {
        RIGHT = 2'd0,
        LEFT  = 2'd1,
        FILL  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0] MSB_ONLY = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] LSB_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ALL_ZERO = {WIDTH{1'b0}};

    logic [WIDTH-1:0] led_q,   led_n;
    logic [DIV_W-1:0] cnt_q,   cnt_n;
    logic [1:0]       mode_q,  mode_n;
    state_t           state_q, state_n;
    logic             step_q,  step_n;
    logic             dir_q,   dir_n;

    // values the pattern would take if it advanced this cycle
    logic [WIDTH-1:0] adv_led;
    state_t           adv_state;
    logic             adv_dir;

    logic [DIV_W-1:0] term;
    logic             one_hot;

    // speed shifts the base period; ">=" lets a speed-up fire immediately
    assign term    = (DIV_W'(BASE_DIV) << bus.speed) - DIV_W'(1);
    assign one_hot = (led_q != ALL_ZERO) && ((led_q & (led_q - LSB_ONE)) == ALL_ZERO);

    // next pattern value for the currently latched mode
    always_comb begin
        adv_led   = led_q;
        adv_state = state_q;
        adv_dir   = dir_q;
        case (mode_q)
            2'b00: begin
                adv_dir   = 1'b0;
                adv_state = RIGHT;
                if (!one_hot || led_q == LSB_ONE) begin
                    adv_led = MSB_ONLY;
                end else begin
                    adv_led = led_q >> 1;
                end
            end
            2'b01: begin
                adv_dir   = 1'b1;
                adv_state = LEFT;
                if (!one_hot || led_q == MSB_ONLY) begin
                    adv_led = LSB_ONE;
                end else begin
                    adv_led = led_q << 1;
                end
            end
            2'b10: begin
                if (!one_hot) begin
                    adv_led   = MSB_ONLY;
                    adv_state = RIGHT;
                    adv_dir   = 1'b0;
                end else if (state_q == LEFT) begin
                    if (led_q == MSB_ONLY) begin
                        adv_led   = led_q >> 1;
                        adv_state = RIGHT;
                        adv_dir   = 1'b0;
                    end else begin
                        adv_led = led_q << 1;
                        adv_dir = 1'b1;
                    end
                end else begin
                    if (led_q == LSB_ONE) begin
                        adv_led   = led_q << 1;
                        adv_state = LEFT;
                        adv_dir   = 1'b1;
                    end else begin
                        adv_led   = led_q >> 1;
                        adv_state = RIGHT;
                        adv_dir   = 1'b0;
                    end
                end
            end
            default: begin
                adv_dir = 1'b0;
                if (state_q == DRAIN) begin
                    if (led_q == ALL_ZERO) begin
                        adv_led   = MSB_ONLY;
                        adv_state = FILL;
                    end else begin
                        adv_led = {1'b0, led_q[WIDTH-1:1]};
                    end
                end else begin
                    adv_led   = {1'b1, led_q[WIDTH-1:1]};
                    adv_state = ({1'b1, led_q[WIDTH-1:1]} == ALL_ONES) ? DRAIN : FILL;
                end
            end
        endcase
    end

    // mode reload takes priority over the prescaler; pause freezes everything
    always_comb begin
        led_n   = led_q;
        cnt_n   = cnt_q;
        mode_n  = mode_q;
        state_n = state_q;
        dir_n   = dir_q;
        step_n  = 1'b0;
        if (bus.mode != mode_q) begin
            mode_n = bus.mode;
            cnt_n  = '0;
            case (bus.mode)
                2'b00: begin led_n = MSB_ONLY; state_n = RIGHT; dir_n = 1'b0; end
                2'b01: begin led_n = LSB_ONE;  state_n = LEFT;  dir_n = 1'b1; end
                2'b10: begin led_n = MSB_ONLY; state_n = RIGHT; dir_n = 1'b0; end
                default: begin led_n = MSB_ONLY; state_n = FILL; dir_n = 1'b0; end
            endcase
        end else if (bus.en) begin
            if (cnt_q >= term) begin
                cnt_n   = '0;
                led_n   = adv_led;
                state_n = adv_state;
                dir_n   = adv_dir;
                step_n  = 1'b1;
            end else begin
                cnt_n = cnt_q + DIV_W'(1);
            end
        end
    end

    // state register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rstn) begin
            led_q   <= MSB_ONLY;
            cnt_q   <= '0;
            mode_q  <= 2'b00;
            state_q <= RIGHT;
            step_q  <= 1'b0;
            dir_q   <= 1'b0;
        end else begin
            led_q   <= led_n;
            cnt_q   <= cnt_n;
            mode_q  <= mode_n;
            state_q <= state_n;
            step_q  <= step_n;
            dir_q   <= dir_n;
        end
    end

    assign bus.led  = led_q;
    assign bus.step = step_q;
    assign bus.dir  = dir_q;

endmodule

// File: tb/tb_led_flow_ctrl.sv
// tb/tb_led_flow_ctrl.sv - randomized and directed bench for led_flow_ctrl
module tb_led_flow_ctrl;

    localparam int W  = 8;
    localparam int BD = 4;

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    int errors = 0;
    int checks = 0;

    led_flow_ctrl_if #(.WIDTH(W)) bus ();

    led_flow_ctrl #(.WIDTH(W), .BASE_DIV(BD), .DIV_W(32)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // reference: each mode is a cyclic sequence indexed by step count
    int   m_mode = 0;
    int   m_idx  = 0;
    int   m_cnt  = 0;
    logic m_step = 1'b0;
    logic m_dir  = 1'b0;

    function automatic int plen(int m);
        if (m == 2) return 2 * (W - 1);
        if (m == 3) return 2 * W;
        return W;
    endfunction

    function automatic int bpos(int k);
        return (k <= W - 1) ? (W - 1 - k) : (k - (W - 1));
    endfunction

    function automatic logic [W-1:0] pat(int m, int k);
        logic [W-1:0] ones;
        logic [W-1:0] one;
        ones = '1;
        one  = 1;
        case (m)
            0: return (one << (W - 1)) >> k;
            1: return one << k;
            2: return one << bpos(k);
            default: begin
                if (k < W) return ~(ones >> (k + 1));
                return ones >> (k - W + 1);
            end
        endcase
    endfunction

    function automatic logic [W+1:0] expv();
        return {pat(m_mode, m_idx), m_step, m_dir};
    endfunction

    task automatic model_edge();
        int nidx;
        if (!rstn) begin
            m_mode = 0; m_idx = 0; m_cnt = 0; m_step = 0; m_dir = 0;
        end else if (int'(bus.mode) != m_mode) begin
            m_mode = int'(bus.mode); m_idx = 0; m_cnt = 0; m_step = 0;
            m_dir  = (m_mode == 1);
        end else if (!bus.en) begin
            m_step = 0;
        end else if (m_cnt >= (BD << bus.speed) - 1) begin
            nidx = (m_idx + 1) % plen(m_mode);
            if (m_mode == 2) m_dir = (bpos(nidx) > bpos(m_idx));
            else             m_dir = (m_mode == 1);
            m_idx  = nidx;
            m_cnt  = 0;
            m_step = 1;
        end else begin
            m_cnt++;
            m_step = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        rstn = 0; bus.en = 1; bus.mode = 2'b00; bus.speed = 2'b00;
        tick(); tick();
        checks++;
        if ({bus.led, bus.step, bus.dir} !== {8'h80, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state got led=%h step=%b dir=%b want 80 0 0", bus.led, bus.step, bus.dir);
        end
    endtask

    task automatic test_rotate_right();
        logic [W-1:0] seen [$];
        logic [W-1:0] exp_rr [9];
        exp_rr = '{8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h80, 8'h40};
        rstn = 1;
        for (int i = 0; i < 36; i++) begin
            tick();
            checks++;
            if ({bus.led, bus.step, bus.dir} !== expv()) begin
                errors++;
                $display("FAIL rr_cycle%0d got %h want %h", i, {bus.led, bus.step, bus.dir}, expv());
            end
            if (bus.step) seen.push_back(bus.led);
        end
        checks++;
        if (seen.size() != 9) begin
            errors++;
            $display("FAIL rr_step_count got %0d want 9", seen.size());
        end else begin
            for (int i = 0; i < 9; i++) begin
                checks++;
                if (seen[i] !== exp_rr[i]) begin
                    errors++;
                    $display("FAIL rr_seq%0d got %h want %h", i, seen[i], exp_rr[i]);
                end
            end
        end
    endtask

    task automatic test_rotate_left();
        tick(); tick();
        bus.mode = 2'b01;
        tick();
        checks++;
        if ({bus.led, bus.step, bus.dir} !== {8'h01, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL rl_reload got %h want %h", {bus.led, bus.step, bus.dir}, {8'h01, 1'b0, 1'b1});
        end
        for (int i = 0; i < 36; i++) begin
            tick();
            checks++;
            if ({bus.led, bus.step, bus.dir} !== expv() || bus.dir !== 1'b1) begin
                errors++;
                $display("FAIL rl_cycle%0d got %h want %h", i, {bus.led, bus.step, bus.dir}, expv());
            end
        end
    endtask

    task automatic test_bounce();
        logic [W-1:0] seen [$];
        logic         dseen [$];
        logic [W-1:0] exp_b [15];
        exp_b = '{8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02,
                  8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40};
        bus.mode = 2'b10;
        tick();
        for (int i = 0; i < 60; i++) begin
            tick();
            checks++;
            if ({bus.led, bus.step, bus.dir} !== expv()) begin
                errors++;
                $display("FAIL bounce_cycle%0d got %h want %h", i, {bus.led, bus.step, bus.dir}, expv());
            end
            if (bus.step) begin
                seen.push_back(bus.led);
                dseen.push_back(bus.dir);
            end
        end
        checks++;
        if (seen.size() != 15) begin
            errors++;
            $display("FAIL bounce_step_count got %0d want 15", seen.size());
        end else begin
            for (int i = 0; i < 15; i++) begin
                checks++;
                if (seen[i] !== exp_b[i] || dseen[i] !== ((i >= 7 && i <= 13) ? 1'b1 : 1'b0)) begin
                    errors++;
                    $display("FAIL bounce_seq%0d got %h/%b want %h/%b", i, seen[i], dseen[i],
                             exp_b[i], (i >= 7 && i <= 13));
                end
            end
        end
    endtask

    task automatic test_bar();
        logic [W-1:0] seen [$];
        logic [W-1:0] exp_f [17];
        exp_f = '{8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF, 8'h7F, 8'h3F,
                  8'h1F, 8'h0F, 8'h07, 8'h03, 8'h01, 8'h00, 8'h80, 8'hC0};
        bus.mode = 2'b11;
        tick();
        for (int i = 0; i < 68; i++) begin
            tick();
            checks++;
            if ({bus.led, bus.step, bus.dir} !== expv()) begin
                errors++;
                $display("FAIL bar_cycle%0d got %h want %h", i, {bus.led, bus.step, bus.dir}, expv());
            end
            if (bus.step) seen.push_back(bus.led);
        end
        checks++;
        if (seen.size() != 17) begin
            errors++;
            $display("FAIL bar_step_count got %0d want 17", seen.size());
        end else begin
            for (int i = 0; i < 17; i++) begin
                checks++;
                if (seen[i] !== exp_f[i]) begin
                    errors++;
                    $display("FAIL bar_seq%0d got %h want %h", i, seen[i], exp_f[i]);
                end
            end
        end
    endtask

    task automatic test_speed();
        bus.mode = 2'b00; bus.speed = 2'b11;
        tick();
        for (int i = 0; i < 20; i++) tick();
        checks++;
        if (bus.led !== 8'h80) begin
            errors++;
            $display("FAIL speed_hold got %h want 80", bus.led);
        end
        bus.speed = 2'b00;
        tick();
        checks++;
        if ({bus.led, bus.step} !== {8'h40, 1'b1}) begin
            errors++;
            $display("FAIL speed_immediate got %h want %h", {bus.led, bus.step}, {8'h40, 1'b1});
        end
        for (int i = 1; i <= 4; i++) begin
            tick();
            checks++;
            if (bus.step !== (i == 4) || {bus.led, bus.step, bus.dir} !== expv()) begin
                errors++;
                $display("FAIL speed_after%0d got step=%b led=%h want step=%b", i, bus.step, bus.led, (i == 4));
            end
        end
    endtask

    task automatic test_pause();
        int when;
        bus.mode = 2'b01;
        tick();
        tick(); tick();
        bus.en = 0;
        for (int i = 0; i < 7; i++) begin
            tick();
            checks++;
            if ({bus.led, bus.step} !== {8'h01, 1'b0}) begin
                errors++;
                $display("FAIL pause_hold%0d got %h want %h", i, {bus.led, bus.step}, {8'h01, 1'b0});
            end
        end
        bus.en = 1;
        when = -1;
        for (int i = 10; i <= 14; i++) begin
            tick();
            if (bus.step && when < 0) when = i;
        end
        checks++;
        if (when != 11) begin
            errors++;
            $display("FAIL pause_delay got step at cycle %0d want 11", when);
        end
    endtask

    task automatic test_reset_mid();
        bus.mode = 2'b11;
        tick();
        for (int i = 0; i < 40; i++) tick();
        checks++;
        if (bus.led !== 8'h1F) begin
            errors++;
            $display("FAIL drain_reach got %h want 1f", bus.led);
        end
        rstn = 0;
        tick();
        checks++;
        if ({bus.led, bus.step, bus.dir} !== {8'h80, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_mid got %h want %h", {bus.led, bus.step, bus.dir}, {8'h80, 1'b0, 1'b0});
        end
        rstn = 1;
        tick();
        checks++;
        if ({bus.led, bus.step} !== {8'h80, 1'b0}) begin
            errors++;
            $display("FAIL reset_reload got %h want %h", {bus.led, bus.step}, {8'h80, 1'b0});
        end
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if ({bus.led, bus.step} !== {8'hC0, 1'b1}) begin
            errors++;
            $display("FAIL reset_fill got %h want %h", {bus.led, bus.step}, {8'hC0, 1'b1});
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(39) == 0) bus.mode  = 2'($urandom_range(3));
            if ($urandom_range(29) == 0) bus.speed = 2'($urandom_range(3));
            if ($urandom_range(9)  == 0) bus.en    = ~bus.en;
            rstn = ($urandom_range(199) != 0);
            tick();
            checks++;
            if ({bus.led, bus.step, bus.dir} !== expv()) begin
                errors++;
                $display("FAIL random_cycle%0d got %h want %h", i, {bus.led, bus.step, bus.dir}, expv());
            end
        end
        rstn = 1;
    endtask

    initial begin
        bus.en = 1; bus.mode = 2'b00; bus.speed = 2'b00;
        test_reset();
        test_rotate_right();
        test_bar();
        test_rotate_left();
        test_bounce();
        test_speed();
        test_pause();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
